seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Multiplexed 7-segment display scanner with double-buffered digit data,
// per-digit decimal point / blink / forced blank, and optional leading-zero
// suppression.
//
// A prescaler divides clk down to one "tick" per digit slot. Each tick
// advances the digit index and registers the segment and select patterns
// for the new digit. A full pass over all digits is one frame. New data
// written with load_i is held in a shadow set and only becomes visible at
// a frame boundary, so a frame never mixes old and new data.
//
// Parameters:
//   NUM_DIGITS     number of multiplexed digits (2..16)
//   CLK_DIV        clk cycles per digit slot (>= 2)
//   BLINK_DIV      frames per blink half-period (>= 1)
//   SEG_ACTIVE_LOW 1: a lit segment drives 0
//   SEL_ACTIVE_LOW 1: the selected digit drives 0
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   digits_i     4 bits per digit, digit 0 in the least significant nibble
//   load_i       one-cycle strobe capturing digits_i/dp_i/blink_i/blank_i
//   dp_i         decimal point enable per digit
//   blink_i      blink enable per digit
//   blank_i      forced blank per digit
//   lzs_en_i     leading-zero suppression enable (sampled every slot)
//   seg_o        registered segments {dp,g,f,e,d,c,b,a}
//   sel_o        registered one-hot digit select
//   frame_done_o one-cycle pulse when the scan returns to digit 0
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 6,
  parameter int CLK_DIV        = 50000,
  parameter int BLINK_DIV      = 250,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic                    load_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blink_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    lzs_en_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   sel_o,
  output logic                    frame_done_o
);

  // ---------------------------------------------------------------------------
  // Derived widths and constants
  // ---------------------------------------------------------------------------
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRESC_W = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
  // A one-frame blink half-period needs no counting; keep a 1-bit counter
  // that simply stays at zero.
  localparam int FCNT_W  = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FCNT_W-1:0]  FCNT_LAST  = FCNT_W'(BLINK_DIV - 1);

  localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ?
                                              {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  // ---------------------------------------------------------------------------
  // Hex to active-high {g,f,e,d,c,b,a}
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    hex_to_seg = 7'h00;
    case (v)
      4'h0: hex_to_seg = 7'b0111111;
      4'h1: hex_to_seg = 7'b0000110;
      4'h2: hex_to_seg = 7'b1011011;
      4'h3: hex_to_seg = 7'b1001111;
      4'h4: hex_to_seg = 7'b1100110;
      4'h5: hex_to_seg = 7'b1101101;
      4'h6: hex_to_seg = 7'b1111101;
      4'h7: hex_to_seg = 7'b0000111;
      4'h8: hex_to_seg = 7'b1111111;
      4'h9: hex_to_seg = 7'b1101111;
      4'hA: hex_to_seg = 7'b1110111;
      4'hB: hex_to_seg = 7'b1111100;
      4'hC: hex_to_seg = 7'b0111001;
      4'hD: hex_to_seg = 7'b1011110;
      4'hE: hex_to_seg = 7'b1111001;
      4'hF: hex_to_seg = 7'b1110001;
      default: hex_to_seg = 7'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PRESC_W-1:0]      presc_reg,       presc_next;
  logic [IDX_W-1:0]        idx_reg,         idx_next;
  logic [FCNT_W-1:0]       fcnt_reg,        fcnt_next;
  logic                    blink_phase_reg, blink_phase_next;
  logic                    pending_reg,     pending_next;

  // Shadow set: written by load_i, invisible to the display.
  logic [4*NUM_DIGITS-1:0] shd_digits_reg,  shd_digits_next;
  logic [NUM_DIGITS-1:0]   shd_dp_reg,      shd_dp_next;
  logic [NUM_DIGITS-1:0]   shd_blink_reg,   shd_blink_next;
  logic [NUM_DIGITS-1:0]   shd_blank_reg,   shd_blank_next;

  // Active set: what the display actually shows; changes only at frame ends.
  logic [4*NUM_DIGITS-1:0] act_digits_reg,  act_digits_next;
  logic [NUM_DIGITS-1:0]   act_dp_reg,      act_dp_next;
  logic [NUM_DIGITS-1:0]   act_blink_reg,   act_blink_next;
  logic [NUM_DIGITS-1:0]   act_blank_reg,   act_blank_next;

  logic [7:0]              seg_reg;
  logic [NUM_DIGITS-1:0]   sel_reg;
  logic                    frame_done_reg;

  logic                    tick;
  logic                    frame_end;

  // ---------------------------------------------------------------------------
  // Timing: prescaler, digit index, frame counter, blink phase
  // ---------------------------------------------------------------------------
  always_comb begin
    tick      = (presc_reg == PRESC_LAST);
    frame_end = tick && (idx_reg == IDX_LAST);

    presc_next = tick ? '0 : presc_reg + 1'b1;

    idx_next = idx_reg;
    if (tick) begin
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end

    fcnt_next        = fcnt_reg;
    blink_phase_next = blink_phase_reg;
    if (frame_end) begin
      if (fcnt_reg == FCNT_LAST) begin
        fcnt_next        = '0;
        blink_phase_next = ~blink_phase_reg;
      end else begin
        fcnt_next = fcnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Double buffering
  // ---------------------------------------------------------------------------
  always_comb begin
    shd_digits_next = shd_digits_reg;
    shd_dp_next     = shd_dp_reg;
    shd_blink_next  = shd_blink_reg;
    shd_blank_next  = shd_blank_reg;
    act_digits_next = act_digits_reg;
    act_dp_next     = act_dp_reg;
    act_blink_next  = act_blink_reg;
    act_blank_next  = act_blank_reg;
    pending_next    = pending_reg;

    if (load_i) begin
      shd_digits_next = digits_i;
      shd_dp_next     = dp_i;
      shd_blink_next  = blink_i;
      shd_blank_next  = blank_i;
      pending_next    = 1'b1;
    end

    if (frame_end) begin
      // A load landing on the boundary bypasses the shadow so that it is
      // shown in the very next frame rather than one frame later.
      if (load_i) begin
        act_digits_next = digits_i;
        act_dp_next     = dp_i;
        act_blink_next  = blink_i;
        act_blank_next  = blank_i;
      end else if (pending_reg) begin
        act_digits_next = shd_digits_reg;
        act_dp_next     = shd_dp_reg;
        act_blink_next  = shd_blink_reg;
        act_blank_next  = shd_blank_reg;
      end
      pending_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-digit rendering
  //
  // Rendering uses the *next* active set and blink phase: the output register
  // loads on the same edge that swaps buffers, so digit 0 of a new frame must
  // already see the new data.
  // ---------------------------------------------------------------------------
  logic [7:0]            pat [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] sel_onehot;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [3:0] nib;
    logic       upper_sig;
    logic       lzs_blank;
    logic       dark;

    assign nib = act_digits_next[4*gi +: 4];

    // Something worth showing at this digit or above: a non-zero nibble or a
    // decimal point. Either one stops suppression from here downward.
    assign upper_sig = |{act_digits_next[4*NUM_DIGITS-1:4*gi],
                         act_dp_next[NUM_DIGITS-1:gi]};

    if (gi == 0) begin : g_lsd
      // The units digit always shows, so a zero value reads "0".
      assign lzs_blank = 1'b0;
    end else begin : g_upper
      assign lzs_blank = lzs_en_i & ~upper_sig;
    end

    assign dark = act_blank_next[gi]
                | (act_blink_next[gi] & blink_phase_next)
                | lzs_blank;

    assign pat[gi]        = dark ? 8'h00 : {act_dp_next[gi], hex_to_seg(nib)};
    assign sel_onehot[gi] = (idx_next == IDX_W'(gi));
  end

  logic [7:0]            seg_disp;
  logic [NUM_DIGITS-1:0] sel_disp;

  always_comb begin
    seg_disp = (SEG_ACTIVE_LOW != 0) ? ~pat[idx_next] : pat[idx_next];
    sel_disp = (SEL_ACTIVE_LOW != 0) ? ~sel_onehot    : sel_onehot;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg       <= '0;
      idx_reg         <= '0;
      fcnt_reg        <= '0;
      blink_phase_reg <= 1'b0;
      pending_reg     <= 1'b0;
      shd_digits_reg  <= '0;
      shd_dp_reg      <= '0;
      shd_blink_reg   <= '0;
      shd_blank_reg   <= '0;
      act_digits_reg  <= '0;
      act_dp_reg      <= '0;
      act_blink_reg   <= '0;
      act_blank_reg   <= '0;
      seg_reg         <= SEG_OFF;
      sel_reg         <= SEL_OFF;
      frame_done_reg  <= 1'b0;
    end else begin
      presc_reg       <= presc_next;
      idx_reg         <= idx_next;
      fcnt_reg        <= fcnt_next;
      blink_phase_reg <= blink_phase_next;
      pending_reg     <= pending_next;
      shd_digits_reg  <= shd_digits_next;
      shd_dp_reg      <= shd_dp_next;
      shd_blink_reg   <= shd_blink_next;
      shd_blank_reg   <= shd_blank_next;
      act_digits_reg  <= act_digits_next;
      act_dp_reg      <= act_dp_next;
      act_blink_reg   <= act_blink_next;
      act_blank_reg   <= act_blank_next;
      // Outputs only move on a slot change; between ticks they hold steady
      // so the display does not flicker with live lzs_en_i changes.
      if (tick) begin
        seg_reg <= seg_disp;
        sel_reg <= sel_disp;
      end
      frame_done_reg  <= frame_end;
    end
  end

  assign seg_o        = seg_reg;
  assign sel_o        = sel_reg;
  assign frame_done_o = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Bench for seg_scan_ctrl with NUM_DIGITS=6, CLK_DIV=4, BLINK_DIV=2, both
// polarities active-low. A reference model derives the expected outputs from
// the number of clocks since reset and the most recent load, and a compare
// process checks every negative clock edge. Directed scenarios add literal
// expectations, then a randomized phase exercises loads, lzs and resets.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int N  = 6;
  localparam int CD = 4;
  localparam int BD = 2;

  logic           clk      = 1'b0;
  logic           rst_n    = 1'b0;
  logic [4*N-1:0] digits_i = '0;
  logic           load_i   = 1'b0;
  logic [N-1:0]   dp_i     = '0;
  logic [N-1:0]   blink_i  = '0;
  logic [N-1:0]   blank_i  = '0;
  logic           lzs_en_i = 1'b0;
  logic [7:0]     seg_o;
  logic [N-1:0]   sel_o;
  logic           frame_done_o;

  int n_cmp = 0;
  int n_mis = 0;

  // Model outputs
  logic [7:0]   exp_seg = 8'hFF;
  logic [N-1:0] exp_sel = '1;
  logic         exp_fd  = 1'b0;

  seg_scan_ctrl #(
    .NUM_DIGITS    (N),
    .CLK_DIV       (CD),
    .BLINK_DIV     (BD),
    .SEG_ACTIVE_LOW(1),
    .SEL_ACTIVE_LOW(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_i    (digits_i),
    .load_i      (load_i),
    .dp_i        (dp_i),
    .blink_i     (blink_i),
    .blank_i     (blank_i),
    .lzs_en_i    (lzs_en_i),
    .seg_o       (seg_o),
    .sel_o       (sel_o),
    .frame_done_o(frame_done_o)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Active-high {g..a} from the decode table.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Segment byte (active-low) that digit idx must show.
  function automatic logic [7:0] render(input int idx, input int phase, input logic lzs,
                                        input logic [4*N-1:0] d, input logic [N-1:0] dp,
                                        input logic [N-1:0] bl, input logic [N-1:0] bk);
    int  hi;
    logic dark;
    logic [3:0] nib;
    hi = -1;  // most significant digit carrying a non-zero value or a dp
    for (int j = 0; j < N; j++) begin
      if (d[4*j +: 4] != 4'h0 || dp[j]) hi = j;
    end
    dark = bk[idx] || (bl[idx] && phase == 1) || (lzs && idx > 0 && idx > hi);
    if (dark) return 8'hFF;
    nib = d[4*idx +: 4];
    return ~{dp[idx], hex7(nib)};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: slot/frame position is plain arithmetic on the count of
  // clocks since reset; each frame shows whatever was loaded most recently
  // at or before the edge that starts it.
  // ---------------------------------------------------------------------------
  initial begin
    int e, ticks, idx, phase;
    logic [4*N-1:0] ld_dig, fr_dig;
    logic [N-1:0]   ld_dp, ld_bl, ld_bk, fr_dp, fr_bl, fr_bk, oh;
    e = 0;
    ld_dig = '0; ld_dp = '0; ld_bl = '0; ld_bk = '0;
    fr_dig = '0; fr_dp = '0; fr_bl = '0; fr_bk = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e = 0;
        ld_dig = '0; ld_dp = '0; ld_bl = '0; ld_bk = '0;
        fr_dig = '0; fr_dp = '0; fr_bl = '0; fr_bk = '0;
        exp_seg = 8'hFF; exp_sel = '1; exp_fd = 1'b0;
      end else begin
        if (load_i) begin
          ld_dig = digits_i; ld_dp = dp_i; ld_bl = blink_i; ld_bk = blank_i;
        end
        exp_fd = 1'b0;
        if (e % CD == CD - 1) begin
          ticks = (e + 1) / CD;
          idx   = ticks % N;
          if (idx == 0) begin
            exp_fd = 1'b1;
            fr_dig = ld_dig; fr_dp = ld_dp; fr_bl = ld_bl; fr_bk = ld_bk;
          end
          phase = ((ticks / N) / BD) % 2;
          oh = '0;
          oh[idx] = 1'b1;
          exp_sel = ~oh;
          exp_seg = render(idx, phase, lzs_en_i, fr_dig, fr_dp, fr_bl, fr_bk);
        end
        e++;
      end
    end
  end

  // Compare process
  initial forever begin
    @(negedge clk);
    chk("seg_o", 32'(seg_o), 32'(exp_seg));
    chk("sel_o", 32'(sel_o), 32'(exp_sel));
    chk("frame_done_o", 32'(frame_done_o), 32'(exp_fd));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called on a negative edge)
  // ---------------------------------------------------------------------------
  task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] dp,
                         input logic [N-1:0] bl, input logic [N-1:0] bk);
    digits_i = d; dp_i = dp; blink_i = bl; blank_i = bk; load_i = 1'b1;
    $display("load digits=%h dp=%b blink=%b blank=%b lzs=%0b t=%0t", d, dp, bl, bk, lzs_en_i, $time);
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame_done_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_mis++;
      $display("FAIL wait_frame_done: no pulse within 60 clk, required one");
    end
  endtask

  task automatic wait_sel(input logic [N-1:0] t, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sel_o == t) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_mis++;
      $display("FAIL wait_sel: sel_o=%b never reached %b", sel_o, t);
    end
  endtask

  // Asynchronous reset mid-cycle, then release on a negative edge.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    $display("reset asserted t=%0t", $time);
    #1;
    chk("rst_async_seg", 32'(seg_o), 'hFF);
    chk("rst_async_sel", 32'(sel_o), 'h3F);
    chk("rst_async_fd", 32'(frame_done_o), 'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit ok;
    int cnt;
    logic [N-1:0]   tgt;
    logic [4*N-1:0] d;
    logic [7:0] lz_a [N];
    logic [7:0] lz_b [N];
    logic [7:0] bl_e [5];
    lz_a = '{8'hC0, 8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    lz_b = '{8'hC0, 8'hF8, 8'hC0, 8'h40, 8'hFF, 8'hFF};
    bl_e = '{8'hFF, 8'hFF, 8'h80, 8'h80, 8'hFF};

    // Reset state and first tick timing
    @(negedge clk);
    @(negedge clk);
    chk("reset_seg", 32'(seg_o), 'hFF);
    chk("reset_sel", 32'(sel_o), 'h3F);
    chk("reset_fd", 32'(frame_done_o), 'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_tick_sel", 32'(sel_o), 'h3F);
    @(negedge clk);
    chk("first_tick_sel", 32'(sel_o), 'b111101);
    chk("first_tick_seg", 32'(seg_o), 'hC0);

    // Basic scan of 0x123456
    do_load(24'h123456, '0, '0, '0);
    wait_fd(ok);
    if (ok) begin
      chk("d0_seg_6", 32'(seg_o), 'h82);
      chk("d0_sel", 32'(sel_o), 'b111110);
    end
    wait_sel(6'b011111, ok);
    if (ok) chk("d5_seg_1", 32'(seg_o), 'hF9);
    wait_fd(ok);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!frame_done_o && cnt < 60);
    chk("frame_period", 32'(cnt), 24);

    // Leading-zero suppression, then dp stopping it
    lzs_en_i = 1'b1;
    do_load(24'h000070, '0, '0, '0);
    wait_fd(ok);
    for (int k = 0; k < N; k++) begin
      tgt = '0; tgt[k] = 1'b1; tgt = ~tgt;
      wait_sel(tgt, ok);
      if (ok) chk("lzs_digit", 32'(seg_o), 32'(lz_a[k]));
    end
    do_load(24'h000070, 6'b001000, '0, '0);
    wait_fd(ok);
    for (int k = 0; k < N; k++) begin
      tgt = '0; tgt[k] = 1'b1; tgt = ~tgt;
      wait_sel(tgt, ok);
      if (ok) chk("lzs_dp_digit", 32'(seg_o), 32'(lz_b[k]));
    end

    // Reset with pending data mid-frame: pending is discarded
    lzs_en_i = 1'b0;
    wait_fd(ok);
    repeat (5) @(negedge clk);
    do_load(24'h999999, '0, '0, '0);
    reset_pulse();
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("post_rst_sel", 32'(sel_o), 'b111101);
    chk("post_rst_seg", 32'(seg_o), 'hC0);
    wait_fd(ok);
    if (ok) chk("post_rst_d0", 32'(seg_o), 'hC0);

    // Blink on digit 0 (first frame boundary after reset already passed)
    do_load(24'h000008, '0, 6'b000001, '0);
    for (int i = 0; i < 5; i++) begin
      wait_fd(ok);
      if (ok) chk("blink_d0", 32'(seg_o), 32'(bl_e[i]));
    end

    // Two loads within one frame: old frame finishes, then last write wins
    wait_fd(ok);
    repeat (5) @(negedge clk);
    do_load(24'h111111, '0, '0, '0);
    repeat (2) @(negedge clk);
    do_load(24'h222222, '0, '0, '0);
    wait_sel(6'b011111, ok);
    if (ok) chk("old_frame_d5", 32'(seg_o), 'hC0);
    wait_fd(ok);
    if (ok) chk("new_frame_d0", 32'(seg_o), 'hA4);

    // Load exactly on a boundary tick: shown in the very next frame
    repeat (23) @(negedge clk);
    digits_i = 24'h000005; dp_i = '0; blink_i = '0; blank_i = '0; load_i = 1'b1;
    $display("load digits=%h on boundary t=%0t", digits_i, $time);
    @(negedge clk);
    load_i = 1'b0;
    chk("bnd_fd", 32'(frame_done_o), 'h1);
    chk("bnd_d0", 32'(seg_o), 'h92);

    // Randomized phase
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 599) == 0) reset_pulse();
      if ($urandom_range(0, 49) == 0) lzs_en_i = ~lzs_en_i;
      if ($urandom_range(0, 11) == 0) begin
        d = 24'($urandom);
        cnt = $urandom_range(0, N);
        for (int j = cnt; j < N; j++) d[4*j +: 4] = 4'h0;
        do_load(d,
                ($urandom_range(0, 3) == 0) ? N'($urandom) : '0,
                ($urandom_range(0, 3) == 0) ? N'($urandom) : '0,
                ($urandom_range(0, 5) == 0) ? N'($urandom) : '0);
      end else begin
        @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
